// File: rtl/ws2812_pkg.sv
// Shared types and elaboration helpers for the WS2812/SK6812 chain driver.
package ws2812_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} ws_state_e;

    // round(ns * clk_hz / 1e9), evaluated at elaboration time.
    function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
        return int'((ns * clk_hz + 64'sd500_000_000) / 64'sd1_000_000_000);
    endfunction

    // (byte * (level + 1)) >> 8, so level 255 leaves the byte unchanged.
    function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] level);
        logic [15:0] p;
        p = 16'(b) * (16'(level) + 16'd1);
        return p[15:8];
    endfunction

endpackage

// File: rtl/ws2812_chain_if.sv
// Pixel stream handshake between a frame source and the chain driver.
interface ws2812_chain_if #(
    parameter int W = 24
);
    logic [W-1:0] px_data;
    logic         px_valid;
    logic         px_ready;

    modport master (output px_data, output px_valid, input px_ready);
    modport slave  (input px_data, input px_valid, output px_ready);
endinterface

// File: rtl/ws2812_bit_tx.sv
// Single NRZ bit generator: a start pulse launches one BIT_CYC-long bit whose
// high phase is T0H_CYC or T1H_CYC; done_o flags the last cycle of the bit.
module ws2812_bit_tx #(
    parameter int T0H_CYC = 40,
    parameter int T1H_CYC = 80,
    parameter int BIT_CYC = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic bit_i,
    output logic out_o,
    output logic high_done_o,
    output logic done_o
);
    localparam int CW = $clog2(BIT_CYC + 1);

    logic          active_q;
    logic          one_q;
    logic          out_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] high_len;

    assign high_len    = one_q ? CW'(T1H_CYC) : CW'(T0H_CYC);
    assign cnt_inc     = cnt_q + 1'b1;
    assign done_o      = active_q && (cnt_q == CW'(BIT_CYC - 1));
    assign high_done_o = active_q && (cnt_inc == high_len);
    assign out_o       = out_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            one_q    <= 1'b0;
            out_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            // A start in the final cycle of a bit chains the next one with no gap.
            active_q <= 1'b1;
            one_q    <= bit_i;
            out_q    <= 1'b1;
            cnt_q    <= '0;
        end else if (done_o) begin
            active_q <= 1'b0;
            out_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (active_q) begin
            cnt_q <= cnt_inc;
            out_q <= (cnt_inc < high_len);
        end
    end

endmodule

// File: rtl/ws2812_chain.sv
// WS2812/SK6812 chain driver: one-pixel skid buffer, chain FSM and latch timer.
// Define WS2812_BRIGHTNESS_EN to add the brightness port and per-byte scaling.
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int NUM_LEDS = 8,
    parameter int CHANNELS = 3,
    parameter int T0H_NS   = 400,
    parameter int T1H_NS   = 800,
    parameter int BIT_NS   = 1250,
    parameter int RESET_US = 80
) (
    input  logic          clk,
    input  logic          rst,
    ws2812_chain_if.slave px,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          busy,
    output logic          frame_done,
    output logic          underrun,
    output logic          out
);
    localparam int PX_W    = 8 * CHANNELS;
    localparam int T0H_CYC = ns_to_cycles(CLK_HZ, T0H_NS);
    localparam int T1H_CYC = ns_to_cycles(CLK_HZ, T1H_NS);
    localparam int BIT_CYC = ns_to_cycles(CLK_HZ, BIT_NS);
    localparam int RST_CYC = ns_to_cycles(CLK_HZ, longint'(RESET_US) * 1000);
    localparam int TMR_W   = $clog2(((RST_CYC > BIT_CYC) ? RST_CYC : BIT_CYC) + 1);
    localparam int PXC_W   = $clog2(NUM_LEDS + 1);
    localparam int BC_W    = $clog2(PX_W);

    if (T0H_CYC >= T1H_CYC || T1H_CYC >= BIT_CYC) begin : g_bad_timing
        $error("ws2812_chain: bit timing must satisfy T0H_CYC < T1H_CYC < BIT_CYC");
    end

    ws_state_e        state_q, state_d;
    logic [PX_W-1:0]  buf_q, buf_d, shreg_q, shreg_d, px_in;
    logic             buf_full_q, buf_full_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PXC_W-1:0] px_cnt_q, px_cnt_d;
    logic [TMR_W-1:0] lat_q, lat_d;
    logic             frame_done_q, frame_done_d;
    logic             underrun_q, underrun_d;
    logic             wr, load_px, tx_start, tx_bit;
    logic             tx_out, tx_high_done, tx_done;

`ifdef WS2812_BRIGHTNESS_EN
    always_comb begin
        px_in = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            px_in[8*i +: 8] = scale_byte(px.px_data[8*i +: 8], brightness);
        end
    end
`else
    assign px_in = px.px_data;
`endif

    assign px.px_ready = rst && !buf_full_q;
    assign wr          = px.px_valid && px.px_ready;
    assign busy        = (state_q != IDLE);
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;
    assign out         = tx_out;

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        px_cnt_d     = px_cnt_q;
        lat_d        = lat_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        load_px      = 1'b0;
        tx_start     = 1'b0;
        tx_bit       = 1'b0;

        if (wr) begin
            buf_d      = px_in;
            buf_full_d = 1'b1;
        end

        case (state_q)
            IDLE:  if (buf_full_q || wr) state_d = LOAD;
            LOAD: begin
                load_px = 1'b1;
                state_d = HIGH;
            end
            HIGH:  if (tx_high_done) state_d = LOW;
            LOW: begin
                if (tx_done) begin
                    if (bit_cnt_q != '0) begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        tx_start  = 1'b1;
                        tx_bit    = shreg_q[PX_W-2];
                        state_d   = HIGH;
                    end else if (px_cnt_q == PXC_W'(NUM_LEDS - 1)) begin
                        px_cnt_d = '0;
                        lat_d    = '0;
                        state_d  = LATCH;
                    end else if (buf_full_q) begin
                        load_px  = 1'b1;
                        px_cnt_d = px_cnt_q + 1'b1;
                        state_d  = HIGH;
                    end else begin
                        underrun_d = 1'b1;
                        px_cnt_d   = '0;
                        lat_d      = '0;
                        state_d    = LATCH;
                    end
                end
            end
            LATCH: begin
                if (lat_q == TMR_W'(RST_CYC - 1)) begin
                    frame_done_d = 1'b1;
                    lat_d        = '0;
                    state_d      = IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The buffer is only read while full, so px_ready already blocks a write.
        if (load_px) begin
            shreg_d    = buf_q;
            bit_cnt_d  = BC_W'(PX_W - 1);
            buf_full_d = 1'b0;
            tx_start   = 1'b1;
            tx_bit     = buf_q[PX_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            px_cnt_q     <= '0;
            lat_q        <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            px_cnt_q     <= px_cnt_d;
            lat_q        <= lat_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    ws2812_bit_tx #(
        .T0H_CYC(T0H_CYC),
        .T1H_CYC(T1H_CYC),
        .BIT_CYC(BIT_CYC)
    ) u_bit_tx (
        .clk        (clk),
        .rst        (rst),
        .start_i    (tx_start),
        .bit_i      (tx_bit),
        .out_o      (tx_out),
        .high_done_o(tx_high_done),
        .done_o     (tx_done)
    );

endmodule

// File: tb/tb_ws2812_chain.sv
// Directed bench: a 2-pixel RGB chain (dut_a) and a 1-pixel RGBW chain (dut_b),
// both with a 1 us latch at 100 MHz; line edges are timestamped at negedge.
module tb_ws2812_chain;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ws2812_chain_if #(.W(24)) if_a ();
    ws2812_chain_if #(.W(32)) if_b ();
    logic       busy_a, fd_a, ur_a, out_a;
    logic       busy_b, fd_b, ur_b, out_b;
    logic [7:0] bright_a = 8'hFF;
    logic [7:0] bright_b = 8'd127;

    ws2812_chain #(.CLK_HZ(100_000_000), .NUM_LEDS(2), .CHANNELS(3), .RESET_US(1)) dut_a (
        .clk(clk), .rst(rst), .px(if_a),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(bright_a),
`endif
        .busy(busy_a), .frame_done(fd_a), .underrun(ur_a), .out(out_a));

    ws2812_chain #(.CLK_HZ(100_000_000), .NUM_LEDS(1), .CHANNELS(4), .RESET_US(1)) dut_b (
        .clk(clk), .rst(rst), .px(if_b),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(bright_b),
`endif
        .busy(busy_b), .frame_done(fd_b), .underrun(ur_b), .out(out_b));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_p1;
    int rise_a[$], fall_a[$], fd_q[$], ur_q[$], acc_q[$];
    int rise_b[$], fall_b[$], fdb_q[$];
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_a && !prev_a) rise_a.push_back(cyc);
        if (!out_a && prev_a) fall_a.push_back(cyc);
        if (fd_a) fd_q.push_back(cyc);
        if (ur_a) ur_q.push_back(cyc);
        if (out_b && !prev_b) rise_b.push_back(cyc);
        if (!out_b && prev_b) fall_b.push_back(cyc);
        if (fd_b) fdb_q.push_back(cyc);
        prev_a = out_a;
        prev_b = out_b;
    end

    task automatic flush_a();
        rise_a.delete(); fall_a.delete(); fd_q.delete(); ur_q.delete();
    endtask

    task automatic push_a(input logic [23:0] d, output int acc);
        int n = 0;
        @(negedge clk);
        if_a.px_data  = d;
        if_a.px_valid = 1'b1;
        while (!if_a.px_ready && n < 20000) begin @(negedge clk); n++; end
        acc = cyc;
        total++;
        if (if_a.px_ready !== 1'b1) begin
            bad++; $display("FAIL push_a_accept: px_ready=%b want 1 within 20000 cycles", if_a.px_ready);
        end
        @(posedge clk); #1;
        if_a.px_valid = 1'b0;
    endtask

    task automatic wait_fd_a(input int want, input int limit);
        int n = 0;
        while (fd_q.size() < want && n < limit) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    // Two back-to-back pixels; every bit timing and the latch length are checked.
    task automatic run_frame_a(input string name, input logic [23:0] p0, input logic [23:0] p1);
        logic [47:0] word;
        int acc0, hi, exp_hi, fd0;
        word = {p0, p1};
        flush_a();
        push_a(p0, acc0);
        fork push_a(p1, acc_p1); join_none
        wait_fd_a(1, 20000);
        fd0 = (fd_q.size() > 0) ? fd_q[0] : -1;
        total++;
        if (fd_q.size() != 1 || ur_q.size() != 0) begin
            bad++; $display("FAIL %s_events: frame_done=%0d underrun=%0d want 1 and 0", name, fd_q.size(), ur_q.size());
        end
        total++;
        if (rise_a.size() != 48 || fall_a.size() != 48) begin
            bad++; $display("FAIL %s_bits: rises=%0d falls=%0d want 48", name, rise_a.size(), fall_a.size());
        end else begin
            total++;
            if (rise_a[0] - acc0 !== 2) begin
                bad++; $display("FAIL %s_latency: got %0d want 2", name, rise_a[0] - acc0);
            end
            exp_hi = 0;
            for (int i = 0; i < 48; i++) begin
                exp_hi = word[47-i] ? 80 : 40;
                hi = fall_a[i] - rise_a[i];
                total++;
                if (hi !== exp_hi) begin
                    bad++; $display("FAIL %s_high[%0d]: got %0d want %0d", name, i, hi, exp_hi);
                end
                if (i > 0) begin
                    total++;
                    if (rise_a[i] - rise_a[i-1] !== 125) begin
                        bad++; $display("FAIL %s_period[%0d]: got %0d want 125", name, i, rise_a[i] - rise_a[i-1]);
                    end
                end
            end
            total++;
            if (fd0 - fall_a[47] !== 125 - exp_hi + 100) begin
                bad++; $display("FAIL %s_latch: got %0d want %0d", name, fd0 - fall_a[47], 125 - exp_hi + 100);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({out_a, busy_a, fd_a, ur_a, if_a.px_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_a: out,busy,fd,ur,ready=%b want 00000", {out_a, busy_a, fd_a, ur_a, if_a.px_ready});
        end
        total++;
        if ({out_b, busy_b, fd_b, ur_b, if_b.px_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_b: out,busy,fd,ur,ready=%b want 00000", {out_b, busy_b, fd_b, ur_b, if_b.px_ready});
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (if_a.px_ready !== 1'b1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL reset_release: ready=%b busy=%b want 1 0", if_a.px_ready, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        run_frame_a("b2b", 24'hFF0000, 24'h000001);
    endtask

    task automatic test_underrun();
        int acc0, n, ur0, fd0, f23;
        flush_a();
        push_a(24'hFF0000, acc0);
        wait_fd_a(1, 20000);
        ur0 = (ur_q.size() > 0) ? ur_q[0] : -1;
        fd0 = (fd_q.size() > 0) ? fd_q[0] : -1;
        f23 = (fall_a.size() > 23) ? fall_a[23] : -1;
        total++;
        if (rise_a.size() != 24) begin
            bad++; $display("FAIL underrun_bits: got %0d want 24", rise_a.size());
        end
        total++;
        if (ur_q.size() != 1 || fd_q.size() != 1) begin
            bad++; $display("FAIL underrun_pulses: underrun=%0d frame_done=%0d want 1 and 1", ur_q.size(), fd_q.size());
        end
        total++;
        if (ur0 - f23 !== 85) begin
            bad++; $display("FAIL underrun_when: got %0d want 85", ur0 - f23);
        end
        total++;
        if (fd0 - ur0 !== 100) begin
            bad++; $display("FAIL underrun_latch: got %0d want 100", fd0 - ur0);
        end
        total++;
        if (busy_a !== 1'b0) begin
            bad++; $display("FAIL underrun_idle: busy=%b want 0", busy_a);
        end
    endtask

    task automatic feed_a(input int k);
        logic [23:0] d;
        int n = 0;
        d = 24'hA50001;
        @(negedge clk);
        if_a.px_data  = d;
        if_a.px_valid = 1'b1;
        while (acc_q.size() < k && n < 30000) begin
            if (if_a.px_ready) begin
                acc_q.push_back(cyc);
                @(posedge clk); #1;
                d = d + 24'd1;
                if_a.px_data = d;
            end
            @(negedge clk);
            n++;
        end
        if_a.px_valid = 1'b0;
    endtask

    task automatic test_stream();
        int fd0;
        flush_a();
        acc_q.delete();
        fork feed_a(4); join_none
        wait_fd_a(2, 20000);
        fd0 = (fd_q.size() > 0) ? fd_q[0] : -1;
        total++;
        if (acc_q.size() != 4 || fd_q.size() != 2) begin
            bad++; $display("FAIL stream_counts: accepted=%0d frames=%0d want 4 and 2", acc_q.size(), fd_q.size());
        end else begin
            total++;
            if (acc_q[1] - acc_q[0] !== 2) begin
                bad++; $display("FAIL stream_ready_rise: got %0d want 2", acc_q[1] - acc_q[0]);
            end
            total++;
            if (acc_q[2] - acc_q[0] !== 3002) begin
                bad++; $display("FAIL stream_third_accept: got %0d want 3002", acc_q[2] - acc_q[0]);
            end
            total++;
            if (acc_q[3] - fd0 !== 2) begin
                bad++; $display("FAIL stream_fourth_accept: got %0d want 2", acc_q[3] - fd0);
            end
            total++;
            if (rise_a.size() != 96 || rise_a[48] - fd0 !== 2) begin
                bad++; $display("FAIL stream_next_frame: rises=%0d start=%0d want 96 and 2", rise_a.size(), rise_a[48] - fd0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc0, n;
        n = 0;
        flush_a();
        push_a(24'hFF0000, acc0);
        while (rise_a.size() < 11 && n < 5000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        total++;
        if (out_a !== 1'b1) begin
            bad++; $display("FAIL midrst_pre: out=%b want 1", out_a);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({out_a, busy_a, if_a.px_ready} !== 3'b000) begin
            bad++; $display("FAIL midrst_async: out,busy,ready=%b want 000", {out_a, busy_a, if_a.px_ready});
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (fd_q.size() != 0 || ur_q.size() != 0 || rise_a.size() != 11) begin
            bad++; $display("FAIL midrst_quiet: frame_done=%0d underrun=%0d rises=%0d want 0 0 11", fd_q.size(), ur_q.size(), rise_a.size());
        end
        run_frame_a("post_rst", 24'hFF0000, 24'h000001);
    endtask

    task automatic test_rgbw();
        logic [31:0] word;
        int n, hi, exp_hi, fd0;
`ifdef WS2812_BRIGHTNESS_EN
        word = 32'h7F40_2000;
`else
        word = 32'hFF80_4000;
`endif
        n = 0;
        rise_b.delete(); fall_b.delete(); fdb_q.delete();
        @(negedge clk);
        if_b.px_data  = 32'hFF80_4000;
        if_b.px_valid = 1'b1;
        @(posedge clk); #1;
        if_b.px_valid = 1'b0;
        while (fdb_q.size() < 1 && n < 20000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        fd0 = (fdb_q.size() > 0) ? fdb_q[0] : -1;
        total++;
        if (rise_b.size() != 32 || fall_b.size() != 32 || fdb_q.size() != 1) begin
            bad++; $display("FAIL rgbw_bits: rises=%0d frames=%0d want 32 and 1", rise_b.size(), fdb_q.size());
        end else begin
            exp_hi = 0;
            for (int i = 0; i < 32; i++) begin
                exp_hi = word[31-i] ? 80 : 40;
                hi = fall_b[i] - rise_b[i];
                total++;
                if (hi !== exp_hi) begin
                    bad++; $display("FAIL rgbw_high[%0d]: got %0d want %0d", i, hi, exp_hi);
                end
                if (i > 0) begin
                    total++;
                    if (rise_b[i] - rise_b[i-1] !== 125) begin
                        bad++; $display("FAIL rgbw_period[%0d]: got %0d want 125", i, rise_b[i] - rise_b[i-1]);
                    end
                end
            end
            total++;
            if (fd0 - fall_b[31] !== 125 - exp_hi + 100) begin
                bad++; $display("FAIL rgbw_latch: got %0d want %0d", fd0 - fall_b[31], 125 - exp_hi + 100);
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.px_valid = 1'b0;
        if_a.px_data  = '0;
        if_b.px_valid = 1'b0;
        if_b.px_data  = '0;
        test_reset();
        test_back_to_back();
        test_underrun();
        test_stream();
        test_reset_mid();
        test_rgbw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
